// File: rtl/cfg_chain_loader.sv
// Serialises host words MSB-first into the LEI/LE configuration chain, one bit per enabled cycle.
// Optional CRC-8 readback/recirculation is compiled in with `define CFG_LOADER_READBACK_EN.
module cfg_chain_loader #(
    parameter int unsigned CHAIN_LEN = 48,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              cfg_en,
    output logic              cfg_data_out,
    input  logic              cfg_data_in,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned NWORDS = CHAIN_LEN / WORD_W;
    localparam int unsigned BIT_W  = $clog2(WORD_W + 1);
    localparam int unsigned WCNT_W = $clog2(NWORDS + 1);

    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W);
    localparam logic [WCNT_W-1:0] WORD_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(NWORDS - 1);

`ifdef CFG_LOADER_READBACK_EN
    localparam int unsigned       CRC_W    = 8;
    localparam logic [CRC_W-1:0]  CRC_POLY = 8'h07;
    localparam logic [CRC_W-1:0]  CRC_INIT = 8'hFF;
    localparam logic [BIT_W-1:0]  VBIT_LAST = BIT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_VERIFY = 2'd2
    } state_t;

    // Serial CRC-8, poly 0x07, MSB-first, no reflection.
    function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] c, input logic b);
        return {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ b) ? CRC_POLY : '0);
    endfunction
`else
    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;
`endif

    state_t              state_q, state_d;
    logic                s_ready_q, s_ready_d;
    logic                cfg_en_q, cfg_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [WORD_W-1:0]   word_buf_q, word_buf_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
`ifdef CFG_LOADER_READBACK_EN
    logic                error_q, error_d;
    logic [CRC_W-1:0]    crc_ld_q, crc_ld_d;
    logic [CRC_W-1:0]    crc_rb_q, crc_rb_d;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        s_ready_d  = s_ready_q;
        cfg_en_d   = cfg_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        word_buf_d = word_buf_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
`ifdef CFG_LOADER_READBACK_EN
        error_d    = error_q;
        crc_ld_d   = crc_ld_q;
        crc_rb_d   = crc_rb_q;
`endif

        if (state_q != S_IDLE && abort) begin
            state_d    = S_IDLE;
            s_ready_d  = 1'b0;
            cfg_en_d   = 1'b0;
            busy_d     = 1'b0;
            word_buf_d = '0;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d    = S_LOAD;
                        s_ready_d  = 1'b1;
                        busy_d     = 1'b1;
                        word_buf_d = '0;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
`ifdef CFG_LOADER_READBACK_EN
                        error_d    = 1'b0;
                        crc_ld_d   = CRC_INIT;
                        crc_rb_d   = CRC_INIT;
`endif
                    end
                end

                S_LOAD: begin
                    if (bit_cnt_q == '0) begin
                        if (s_valid && s_ready_q) begin
                            word_buf_d = s_data;
                            bit_cnt_d  = BIT_ONE;
                            cfg_en_d   = 1'b1;
                            s_ready_d  = 1'b0;
                        end
                    end else begin
                        // Buffer MSB is on cfg_data_out this cycle; advance to the next bit.
                        word_buf_d = {word_buf_q[WORD_W-2:0], 1'b0};
`ifdef CFG_LOADER_READBACK_EN
                        crc_ld_d   = crc8_step(crc_ld_q, word_buf_q[WORD_W-1]);
`endif
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d  = '0;
                            word_cnt_d = word_cnt_q + WORD_ONE;
                            cfg_en_d   = 1'b0;
                            if (word_cnt_q == WORD_LAST) begin
`ifdef CFG_LOADER_READBACK_EN
                                state_d    = S_VERIFY;
                                cfg_en_d   = 1'b1;
                                word_cnt_d = '0;
`else
                                state_d    = S_IDLE;
                                busy_d     = 1'b0;
                                done_d     = 1'b1;
`endif
                            end else begin
                                s_ready_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_ONE;
                        end
                    end
                end

`ifdef CFG_LOADER_READBACK_EN
                S_VERIFY: begin
                    // Tail bit is fed straight back to the head, so one full pass restores the chain.
                    crc_rb_d = crc8_step(crc_rb_q, cfg_data_in);
                    if (bit_cnt_q == VBIT_LAST) begin
                        bit_cnt_d = '0;
                        if (word_cnt_q == WORD_LAST) begin
                            state_d    = S_IDLE;
                            cfg_en_d   = 1'b0;
                            busy_d     = 1'b0;
                            word_cnt_d = '0;
                            if (crc_rb_d == crc_ld_q) begin
                                done_d = 1'b1;
                            end else begin
                                error_d = 1'b1;
                            end
                        end else begin
                            word_cnt_d = word_cnt_q + WORD_ONE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end
`endif

                default: begin
                    state_d    = S_IDLE;
                    s_ready_d  = 1'b0;
                    cfg_en_d   = 1'b0;
                    busy_d     = 1'b0;
                    word_buf_d = '0;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            s_ready_q  <= 1'b0;
            cfg_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            word_buf_q <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
`ifdef CFG_LOADER_READBACK_EN
            error_q    <= 1'b0;
            crc_ld_q   <= '0;
            crc_rb_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            s_ready_q  <= s_ready_d;
            cfg_en_q   <= cfg_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            word_buf_q <= word_buf_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
`ifdef CFG_LOADER_READBACK_EN
            error_q    <= error_d;
            crc_ld_q   <= crc_ld_d;
            crc_rb_q   <= crc_rb_d;
`endif
        end
    end

    assign s_ready = s_ready_q;
    assign cfg_en  = cfg_en_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef CFG_LOADER_READBACK_EN
    assign cfg_data_out = (state_q == S_VERIFY) ? cfg_data_in : word_buf_q[WORD_W-1];
    assign error        = error_q;
`else
    logic unused_cfg_data_in;
    assign unused_cfg_data_in = cfg_data_in;
    assign cfg_data_out       = word_buf_q[WORD_W-1];
    assign error              = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Scoreboard bench for cfg_chain_loader driving a 48-bit behavioural shift chain.
module tb_cfg_chain_loader;

    localparam int unsigned CHAIN_LEN = 48;
    localparam int unsigned WORD_W    = 8;
    localparam logic [47:0] CHAIN_EXP = 48'hA53CFF00817E;
    localparam int          EV_DONE   = 1;
    localparam int          EV_ERR    = 2;
`ifdef CFG_LOADER_READBACK_EN
    localparam int          OP_SHIFTS = 96;
`else
    localparam int          OP_SHIFTS = 48;
`endif

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready, cfg_en, cfg_data_out, cfg_data_in, busy, done, error;

    logic [47:0] chain = '0;
    int          shifts = 0;
    int          flip_at = -1;
`ifdef CFG_LOADER_READBACK_EN
    int          flip_k = -1;
`endif
    int          checks = 0;
    int          errors = 0;
    int          en_cnt = 0;
    logic        prev_en = 1'b0;
    logic        prev_err = 1'b0;
    logic        exp_bits[$];
    int          exp_evt[$];
    logic [7:0]  words [6];

    cfg_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .start        (start),
        .abort        (abort),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .cfg_en       (cfg_en),
        .cfg_data_out (cfg_data_out),
        .cfg_data_in  (cfg_data_in),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    assign cfg_data_in = chain[47];

    // Downstream chain: head takes cfg_data_out, tail drives cfg_data_in; optional one-shot bit flip.
    initial forever begin
        logic [47:0] nx;
        @(posedge clk);
        if (cfg_en) begin
            nx = {chain[46:0], cfg_data_out};
            shifts = shifts + 1;
            if (shifts == flip_at) nx[17] = ~nx[17];
            chain <= nx;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected serial bits and completion events as the DUT presents them.
    initial forever begin
        logic b;
        int   ev;
        @(negedge clk);
        if (!nrst) begin
            prev_en  = 1'b0;
            prev_err = 1'b0;
        end else begin
            if (cfg_en) begin
                en_cnt++;
                if (exp_bits.size() == 0) begin
                    chk("spurious_cfg_en", 64'(cfg_en), 64'd0);
                end else begin
                    b = exp_bits.pop_front();
                    chk("serial_bit", 64'(cfg_data_out), 64'(b));
                end
            end
            if (done) begin
                if (exp_evt.size() == 0) begin
                    chk("spurious_done", 64'(done), 64'd0);
                end else begin
                    ev = exp_evt.pop_front();
                    chk("done_event", 64'(ev), 64'(EV_DONE));
                end
                chk("done_after_last_shift", 64'({prev_en, cfg_en, busy}), 64'(3'b100));
            end
            if (error && !prev_err) begin
                if (exp_evt.size() == 0) begin
                    chk("spurious_error", 64'(error), 64'd0);
                end else begin
                    ev = exp_evt.pop_front();
                    chk("error_event", 64'(ev), 64'(EV_ERR));
                end
                chk("error_after_last_shift", 64'({prev_en, cfg_en, busy, done}), 64'(4'b1000));
            end
            prev_en  = cfg_en;
            prev_err = error;
        end
    end

    task automatic push_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(w[i]);
    endtask

    // Expectations that follow the last loaded word: verify stream (if built) and the end event.
    task automatic push_tail();
`ifdef CFG_LOADER_READBACK_EN
        logic [47:0] ce;
        ce = CHAIN_EXP;
        for (int j = 0; j < 48; j++) exp_bits.push_back(ce[47-j] ^ (j == flip_k));
        exp_evt.push_back((flip_k >= 0) ? EV_ERR : EV_DONE);
`else
        exp_evt.push_back(EV_DONE);
`endif
    endtask

    task automatic start_load();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_state", 64'({s_ready, busy, cfg_en, error}), 64'(4'b1100));
    endtask

    task automatic send_word(input logic [7:0] w, input bit last, input int gap, input bit measure);
        int n;
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = w;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            chk("accept_timeout", 64'(s_ready), 64'd1);
            s_valid = 1'b0;
            return;
        end
        push_word(w);
        if (last) push_tail();
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        if (measure) begin
            n = 0;
            @(negedge clk);
            while (!s_ready && n < 20) begin
                n++;
                @(negedge clk);
            end
            chk("s_ready_low_cycles", 64'(n), 64'd8);
            repeat (gap) begin
                @(negedge clk);
                chk("cfg_en_in_gap", 64'(cfg_en), 64'd0);
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("busy_clears", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic end_checks(input int base, input logic [47:0] exp_chain);
        chk("chain_contents", 64'(chain), 64'(exp_chain));
        chk("shift_count", 64'(en_cnt - base), 64'(OP_SHIFTS));
        chk("queues_drained", 64'(exp_bits.size() + exp_evt.size()), 64'd0);
    endtask

    task automatic load_frame(input int gap, input bit measure, input logic [47:0] exp_chain);
        int base;
        base = en_cnt;
        start_load();
        for (int i = 0; i < 6; i++) send_word(words[i], (i == 5), gap, measure && (i < 5));
        wait_idle();
        end_checks(base, exp_chain);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({s_ready, cfg_en, cfg_data_out, busy, done, error}), 64'd0);
        nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_reset", 64'({s_ready, cfg_en, busy}), 64'd0);

        // Back-to-back words
        load_frame(0, 1'b0, CHAIN_EXP);

        // Throttled host with idle gaps between words
        load_frame(2, 1'b1, CHAIN_EXP);

        // Abort in the middle of word 3
        base = en_cnt;
        start_load();
        for (int i = 0; i < 4; i++) send_word(words[i], 1'b0, 0, 1'b0);
        n = 0;
        while ((en_cnt - base) < 28 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("abort_reach_bit", 64'(en_cnt - base), 64'd28);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_outputs", 64'({cfg_en, busy, s_ready, done, error}), 64'd0);
        chk("abort_shift_count", 64'(en_cnt - base), 64'd29);
        chk("abort_bits_left", 64'(exp_bits.size()), 64'd3);
        exp_bits.delete();
        repeat (4) @(posedge clk);
        #1;
        chk("abort_stays_idle", 64'({busy, done, cfg_en}), 64'd0);
        load_frame(0, 1'b0, CHAIN_EXP);

`ifdef CFG_LOADER_READBACK_EN
        // Corrupt chain bit 17 after the load: verify must flag it and leave done low
        flip_k  = 30;
        flip_at = shifts + 48;
        load_frame(0, 1'b0, CHAIN_EXP ^ 48'h0000_0002_0000);
        chk("error_set", 64'(error), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("error_sticky", 64'({error, done}), 64'(2'b10));
        flip_k  = -1;
        flip_at = -1;
        load_frame(0, 1'b0, CHAIN_EXP);
        chk("error_cleared", 64'(error), 64'd0);
`endif

        // start pulsed mid-LOAD is ignored
        base = en_cnt;
        start_load();
        send_word(words[0], 1'b0, 0, 1'b0);
        send_word(words[1], 1'b0, 0, 1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 2; i < 6; i++) send_word(words[i], (i == 5), 0, 1'b0);
        wait_idle();
        end_checks(base, CHAIN_EXP);

        // Asynchronous reset in the middle of a load
        start_load();
        send_word(words[0], 1'b0, 0, 1'b0);
        send_word(words[1], 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_busy", 64'({busy, cfg_en}), 64'(2'b11));
        nrst = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({s_ready, cfg_en, cfg_data_out, busy, done, error}), 64'd0);
        exp_bits.delete();
        exp_evt.delete();
        @(posedge clk); #1;
        nrst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_midload_reset", 64'({s_ready, cfg_en, busy, done}), 64'd0);
        load_frame(0, 1'b0, CHAIN_EXP);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
